// File: rtl/key_debounce.sv
// Conditions raw active-low push-buttons into debounced levels plus
// press / release / long-press single-cycle pulses, all in the sys_clk domain.
module key_debounce #(
  parameter int unsigned KEY_W        = 4,
  parameter logic [24:0] debounce_val = 25'd999_999,
  parameter logic [25:0] hold_val     = 26'd49_999_999
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_hold
);

  localparam logic [24:0] DB_LAST   = debounce_val - 25'd1;
  localparam logic [25:0] HOLD_LAST = hold_val - 26'd1;

  logic [KEY_W-1:0] sync1;
  logic [KEY_W-1:0] sync2;

  // Preset to released so a key held through reset is seen as a fresh press.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    logic [24:0] db_cnt;
    logic [25:0] hold_cnt;
    logic        state_q;
    logic        press_q;
    logic        release_q;
    logic        hold_q;
    logic        diff;

    always_comb begin
      diff = (~sync2[k]) != state_q;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt    <= '0;
        state_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (!diff) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_cnt    <= '0;
          state_q   <= ~state_q;
          press_q   <= ~state_q;
          release_q <= state_q;
        end else begin
          db_cnt <= db_cnt + 25'd1;
        end
      end
    end

    // Counter saturates at hold_val, so the match below can occur once per press.
    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt <= '0;
        hold_q   <= 1'b0;
      end else if (!state_q) begin
        hold_cnt <= '0;
        hold_q   <= 1'b0;
      end else begin
        hold_q <= (hold_cnt == HOLD_LAST);
        if (hold_cnt != hold_val) begin
          hold_cnt <= hold_cnt + 26'd1;
        end
      end
    end

    assign key_state[k]   = state_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_hold[k]    = hold_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with debounce_val=10, hold_val=50.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_hold;

  int compared   = 0;
  int mismatched = 0;

  always #10 clk = ~clk;

  key_debounce #(
    .KEY_W       (4),
    .debounce_val(25'd10),
    .hold_val    (26'd50)
  ) dut (
    .sys_clk    (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ok;
    rst_n  = 1'b0;
    key_in = 4'b0000;
    repeat (3) tick();
    compared++;
    if ({key_state, key_press, key_release, key_hold} !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h expected 0000", {key_state, key_press, key_release, key_hold});
    end
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (11) begin
      tick();
      if (key_state !== 4'b0000 || key_press !== 4'b0000) ok = 1'b0;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL reset_early: state %b press %b changed before edge 12", key_state, key_press);
    end
    tick();
    compared++;
    if (key_state !== 4'b1111) begin
      mismatched++;
      $display("FAIL reset_state12: got %b expected 1111", key_state);
    end
    compared++;
    if (key_press !== 4'b1111) begin
      mismatched++;
      $display("FAIL reset_press12: got %b expected 1111", key_press);
    end
    tick();
    compared++;
    if (key_press !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_press13: got %b expected 0000", key_press);
    end
    key_in = 4'b1111;
    ok = 1'b1;
    repeat (11) begin
      tick();
      if (key_release !== 4'b0000 || key_state !== 4'b1111 || key_hold !== 4'b0000) ok = 1'b0;
    end
    tick();
    compared++;
    if (!ok || key_release !== 4'b1111 || key_state !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_release: early_ok %b release %b state %b expected 1111/0000", ok, key_release, key_state);
    end
    tick();
    compared++;
    if (key_release !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_release_pulse: got %b expected 0000", key_release);
    end
  endtask

  task automatic test_clean_press();
    logic ok = 1'b1;
    key_in[0] = 1'b0;
    repeat (11) begin
      tick();
      if (key_state[0] !== 1'b0 || key_press[0] !== 1'b0) ok = 1'b0;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL clean_early: state/press seen before edge 12 (now %b %b)", key_state[0], key_press[0]);
    end
    tick();
    compared++;
    if (key_state[0] !== 1'b1 || key_press[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL clean_edge12: state %b press %b expected 1 1", key_state[0], key_press[0]);
    end
    tick();
    compared++;
    if (key_state[0] !== 1'b1 || key_press[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL clean_edge13: state %b press %b expected 1 0", key_state[0], key_press[0]);
    end
    key_in[0] = 1'b1;
    repeat (11) tick();
    tick();
    compared++;
    if (key_state[0] !== 1'b0 || key_release[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL clean_release: state %b release %b expected 0 1", key_state[0], key_release[0]);
    end
    tick();
  endtask

  task automatic test_bounce();
    logic ok = 1'b1;
    repeat (3) begin
      key_in[1] = 1'b0;
      repeat (5) begin
        tick();
        if (key_state !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) ok = 1'b0;
      end
      key_in[1] = 1'b1;
      tick();
      if (key_state !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000) ok = 1'b0;
    end
    key_in[1] = 1'b0;
    repeat (11) begin
      tick();
      if (key_state !== 4'b0000 || key_press !== 4'b0000) ok = 1'b0;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL bounce_quiet: output activity during bounce (state %b press %b)", key_state, key_press);
    end
    tick();
    compared++;
    if (key_state !== 4'b0010 || key_press !== 4'b0010) begin
      mismatched++;
      $display("FAIL bounce_accept: state %b press %b expected 0010 0010", key_state, key_press);
    end
    key_in[1] = 1'b1;
    repeat (14) tick();
    compared++;
    if (key_state !== 4'b0000) begin
      mismatched++;
      $display("FAIL bounce_cleanup: state %b expected 0000", key_state);
    end
  endtask

  task automatic test_long_press();
    int n_press = 0, n_hold = 0, n_rel = 0, n_hold2 = 0;
    int press_edge = 0, hold_edge = 0, rel_edge = 0;
    key_in[2] = 1'b0;
    for (int e = 1; e <= 80; e++) begin
      tick();
      if (key_press[2] === 1'b1) begin n_press++; press_edge = e; end
      if (key_hold[2] === 1'b1) begin n_hold++; hold_edge = e; end
    end
    compared++;
    if (n_press != 1 || press_edge != 12) begin
      mismatched++;
      $display("FAIL long_press: count %0d at edge %0d expected 1 at 12", n_press, press_edge);
    end
    compared++;
    if (n_hold != 1 || hold_edge != 62) begin
      mismatched++;
      $display("FAIL long_hold: count %0d at edge %0d expected 1 at 62", n_hold, hold_edge);
    end
    key_in[2] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (key_release[2] === 1'b1) begin n_rel++; rel_edge = e; end
      if (key_hold[2] === 1'b1) n_hold2++;
    end
    compared++;
    if (n_rel != 1 || rel_edge != 12 || n_hold2 != 0) begin
      mismatched++;
      $display("FAIL long_release: rel %0d at %0d extra_hold %0d expected 1 at 12, 0", n_rel, rel_edge, n_hold2);
    end
  endtask

  task automatic test_short_press();
    int n_press = 0, n_rel = 0, n_hold = 0;
    key_in[3] = 1'b0;
    repeat (30) begin
      tick();
      if (key_press[3] === 1'b1) n_press++;
      if (key_hold[3] === 1'b1) n_hold++;
    end
    key_in[3] = 1'b1;
    repeat (60) begin
      tick();
      if (key_release[3] === 1'b1) n_rel++;
      if (key_hold[3] === 1'b1) n_hold++;
      if (key_press[3] === 1'b1) n_press++;
    end
    compared++;
    if (n_press != 1 || n_rel != 1 || n_hold != 0) begin
      mismatched++;
      $display("FAIL short_press: press %0d release %0d hold %0d expected 1 1 0", n_press, n_rel, n_hold);
    end
  endtask

  task automatic test_reset_mid_count();
    logic ok = 1'b1;
    key_in[0] = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    compared++;
    if ({key_state, key_press, key_release, key_hold} !== 16'h0000) begin
      mismatched++;
      $display("FAIL midreset_outputs: got %h expected 0000", {key_state, key_press, key_release, key_hold});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (11) begin
      tick();
      if (key_state[0] !== 1'b0 || key_press[0] !== 1'b0) ok = 1'b0;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL midreset_early: press before fresh window (state %b press %b)", key_state[0], key_press[0]);
    end
    tick();
    compared++;
    if (key_state !== 4'b0001 || key_press !== 4'b0001) begin
      mismatched++;
      $display("FAIL midreset_accept: state %b press %b expected 0001 0001", key_state, key_press);
    end
    key_in[0] = 1'b1;
    repeat (14) tick();
  endtask

  task automatic test_simultaneous();
    logic ok = 1'b1;
    key_in[1] = 1'b0;
    key_in[2] = 1'b0;
    repeat (11) begin
      tick();
      if (key_press !== 4'b0000) ok = 1'b0;
    end
    tick();
    compared++;
    if (!ok || key_press !== 4'b0110 || key_state !== 4'b0110) begin
      mismatched++;
      $display("FAIL simul_press: early_ok %b press %b state %b expected 0110 0110", ok, key_press, key_state);
    end
    key_in[1] = 1'b1;
    key_in[2] = 1'b1;
    repeat (11) tick();
    tick();
    compared++;
    if (key_release !== 4'b0110 || key_state !== 4'b0000 || key_press !== 4'b0000) begin
      mismatched++;
      $display("FAIL simul_release: release %b state %b press %b expected 0110 0000 0000", key_release, key_state, key_press);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_short_press();
    test_reset_mid_count();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
